// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared definitions for the asynchronous FIFO pointer handlers.
//               Provides the default pointer width, the FIFO depth derivation
//               and the binary/Gray conversion helpers. The helpers operate on
//               a fixed maximum-width word; narrower pointers are zero-extended
//               on the way in and truncated on the way out. Leading zeros do
//               not change either conversion.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Default address width; pointers carry one extra wrap bit.
    localparam int unsigned PTR_WIDTH_DFLT = 3;

    // Widest pointer the conversion helpers accept.
    localparam int unsigned PTR_MAX_W = 16;

    typedef logic [PTR_MAX_W:0] ptr_max_t;

    // FIFO depth for a given address width.
    function automatic int unsigned fifo_depth(input int unsigned ptr_width);
        return 32'd1 << ptr_width;
    endfunction

    function automatic ptr_max_t bin2gray(input ptr_max_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    function automatic ptr_max_t gray2bin(input ptr_max_t gray);
        ptr_max_t bin;
        bin = gray;
        for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/gray2bin_conv.sv
`default_nettype none
// ============================================================================
// Module      : gray2bin_conv
// Description : Combinational Gray-to-binary converter. Each binary bit is the
//               XOR of all Gray bits at or above its position, built as a
//               prefix chain running from the MSB down.
// Ports       : gray_i [W-1:0]  Gray-coded input word
//               bin_o  [W-1:0]  binary equivalent
// Revision    : 1.0 - initial release
// ============================================================================
module gray2bin_conv #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    // Running XOR of the Gray bits seen so far, from the MSB downward.
    logic acc;

    always_comb begin
        acc   = 1'b0;
        bin_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            acc      = acc ^ gray_i[i];
            bin_o[i] = acc;
        end
    end

endmodule : gray2bin_conv
`default_nettype wire

// File: rtl/rptr_handler.sv
`default_nettype none
// ============================================================================
// Module      : rptr_handler
// Description : Read-side pointer and status manager of the asynchronous FIFO.
//               Lives entirely in the read clock domain. It keeps the binary
//               and Gray read pointers, accepts reads, and compares against
//               the write pointer once it has been synchronised into rclk.
//               All status outputs are registered.
// Ports       : rclk, rrst        read clock, synchronous active-high reset
//               r_en              read request
//               clr_err           clear the sticky error flags
//               g_wptr_sync       synchronised Gray write pointer
//               b_rptr, g_rptr    binary / Gray read pointer
//               rd_addr           memory read address
//               rd_fire           read accepted this cycle (combinational)
//               empty             FIFO empty
//               almost_empty      fill level at or below AE_THRESH
//               r_count           fill level, saturated to DEPTH
//               underflow         sticky: read attempted while empty
//               ptr_err           sticky: pointer distance exceeded DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module rptr_handler
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 r_en,
    input  logic                 clr_err,
    input  logic [PTR_WIDTH:0]   g_wptr_sync,
    output logic [PTR_WIDTH:0]   b_rptr,
    output logic [PTR_WIDTH:0]   g_rptr,
    output logic [PTR_WIDTH-1:0] rd_addr,
    output logic                 rd_fire,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   r_count,
    output logic                 underflow,
    output logic                 ptr_err
);

    localparam int unsigned        DEPTH     = fifo_depth(PTR_WIDTH);
    localparam logic [PTR_WIDTH:0] DEPTH_V   = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AE_THR_V  = (PTR_WIDTH+1)'(AE_THRESH);

    logic [PTR_WIDTH:0] b_rptr_q, b_rptr_d;
    logic [PTR_WIDTH:0] g_rptr_q, g_rptr_d;
    logic [PTR_WIDTH:0] count_q,  count_d;
    logic               empty_q,  empty_d;
    logic               ae_q,     ae_d;
    logic               uf_q,     uf_d;
    logic               perr_q,   perr_d;

    logic [PTR_WIDTH:0] b_wptr_bin;
    logic [PTR_WIDTH:0] count_raw;

    gray2bin_conv #(
        .W (PTR_WIDTH + 1)
    ) u_wptr_g2b (
        .gray_i (g_wptr_sync),
        .bin_o  (b_wptr_bin)
    );

    assign rd_fire = r_en & ~empty_q;

    always_comb begin
        b_rptr_d  = b_rptr_q + {{PTR_WIDTH{1'b0}}, rd_fire};
        g_rptr_d  = (b_rptr_d >> 1) ^ b_rptr_d;

        // Modular difference; a value above DEPTH can only come from a
        // corrupted or out-of-step write pointer.
        count_raw = b_wptr_bin - b_rptr_d;
        count_d   = (count_raw > DEPTH_V) ? DEPTH_V : count_raw;

        // Full Gray compare, MSB included, so full and empty stay distinct.
        empty_d   = (g_rptr_d == g_wptr_sync);
        ae_d      = (count_d <= AE_THR_V);

        // Sticky flags: a set condition overrides a simultaneous clear.
        uf_d = uf_q;
        if (r_en && empty_q) begin
            uf_d = 1'b1;
        end else if (clr_err) begin
            uf_d = 1'b0;
        end

        perr_d = perr_q;
        if (count_raw > DEPTH_V) begin
            perr_d = 1'b1;
        end else if (clr_err) begin
            perr_d = 1'b0;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            b_rptr_q <= '0;
            g_rptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            ae_q     <= 1'b1;
            uf_q     <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            b_rptr_q <= b_rptr_d;
            g_rptr_q <= g_rptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            ae_q     <= ae_d;
            uf_q     <= uf_d;
            perr_q   <= perr_d;
        end
    end

    assign b_rptr       = b_rptr_q;
    assign g_rptr       = g_rptr_q;
    assign rd_addr      = b_rptr_q[PTR_WIDTH-1:0];
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign r_count      = count_q;
    assign underflow    = uf_q;
    assign ptr_err      = perr_q;

endmodule : rptr_handler
`default_nettype wire

// File: doc/rptr_handler.md
Name: rptr_handler

Overview:
- Read-side pointer and status manager for the asynchronous FIFO. It is the counterpart of the write-pointer handler.
- Runs entirely in the read clock domain. It keeps the binary and Gray read pointers and accepts reads.
- Compares against the write pointer after that pointer has been synchronised into this domain.
- Produces registered empty, almost-empty, fill level and sticky error flags for the FIFO top level and the memory read port.

Parameters:
- PTR_WIDTH, 3: address width. FIFO depth is DEPTH = 2**PTR_WIDTH. Pointers are PTR_WIDTH+1 bits wide.
- AE_THRESH, 1: almost_empty asserts when the fill level is at or below this value. Legal range is 0..DEPTH-1.

Ports:
- rclk  in  1  read-domain clock; all logic is on the rising edge.
- rrst  in  1  synchronous, active-high reset.
- r_en  in  1  read request from the consumer.
- clr_err  in  1  synchronous clear of the sticky error flags.
- g_wptr_sync  in  PTR_WIDTH+1  Gray write pointer, already double-flopped into rclk.
- b_rptr  out  PTR_WIDTH+1  binary read pointer (registered).
- g_rptr  out  PTR_WIDTH+1  Gray read pointer (registered); goes to the write-domain synchroniser.
- rd_addr  out  PTR_WIDTH  memory read address, equal to b_rptr[PTR_WIDTH-1:0].
- rd_fire  out  1  combinational; r_en & !empty, meaning the read is accepted this cycle.
- empty  out  1  registered empty flag.
- almost_empty  out  1  registered; r_count <= AE_THRESH.
- r_count  out  PTR_WIDTH+1  registered fill level, 0..DEPTH.
- underflow  out  1  sticky; a read was attempted while empty.
- ptr_err  out  1  sticky; the decoded distance between pointers exceeded DEPTH.

Behaviour:
- Reset (rrst=1 at a rising edge) applies these values, and takes priority over every other event in the same cycle:
  - b_rptr=0, g_rptr=0
  - empty=1, almost_empty=1, r_count=0
  - underflow=0, ptr_err=0
- Next-state logic:
  - b_rptr_next = b_rptr + rd_fire, modulo 2**(PTR_WIDTH+1). From all-ones it wraps to 0, and the MSB toggles on each pass through the address space.
  - g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next.
  - b_wptr_bin = gray2bin(g_wptr_sync). This is purely combinational.
  - count_next = b_wptr_bin - b_rptr_next, modulo 2**(PTR_WIDTH+1), unsigned.
- Registered updates each cycle:
  - b_rptr <= b_rptr_next and g_rptr <= g_rptr_next.
  - empty <= (g_rptr_next == g_wptr_sync). The full Gray word is compared, including the MSB.
  - r_count <= count_next, saturated to DEPTH.
  - almost_empty <= (saturated count_next <= AE_THRESH).
- Latency:
  - A read accepted in cycle N updates the pointers and flags at the edge ending cycle N.
  - A write becomes visible only when g_wptr_sync changes. empty deasserts at the first rclk edge after that change, so empty is pessimistic, never optimistic.
- Read while empty: r_en=1 with empty=1 means rd_fire=0, the pointers hold, and underflow<=1.
- ptr_err is set when the unsaturated count_next > DEPTH. The pointers are unaffected.
- Sticky flags:
  - clr_err=1 clears underflow and ptr_err.
  - If a set condition and clr_err occur in the same cycle, set wins.
- Read and write in the same cycle: the pointer increment and the new g_wptr_sync are both folded into the next-state values. The count stays unchanged when one read and one write coincide.
- At full (count=DEPTH), the pointers differ only in the top two Gray bits. empty=0 and r_count=DEPTH.
- Reset mid-stream: the pointers return to 0 regardless of g_wptr_sync. The top level is required to reset both domains together.

Decomposition:
- Shared package fifo_pkg holds:
  - the DEPTH derivation from PTR_WIDTH
  - the bin2gray and gray2bin functions, shared with wptr_handler
  - the pointer-width constant.
- One sub-module, gray2bin_conv: a parameterised combinational Gray-to-binary converter built as an XOR prefix chain from the MSB down. It is instantiated once for g_wptr_sync.

Test Plan (PTR_WIDTH=3, AE_THRESH=1):
- Reset: assert rrst for 2 cycles with g_wptr_sync=4'b0110 -> b_rptr=0, g_rptr=0, empty=1, almost_empty=1, r_count=0, flags=0.
- Drain: drive g_wptr_sync=gray(3)=4'b0010 and hold r_en=1 -> rd_fire for 3 cycles; b_rptr goes 1,2,3; r_count goes 2,1,0. almost_empty rises when r_count reaches 1. empty=1 after the third read.
- Underflow: with empty=1, pulse r_en once -> b_rptr is unchanged and underflow=1 persists. One cycle of clr_err -> underflow=0.
- Wrap: write pointer at gray(17 mod 16 = 1) after 16 reads from a b_rptr=15 base. Result: b_rptr goes 4'b1111 -> 4'b0000, g_rptr goes 4'b1000 -> 4'b0000, and empty is correct across the MSB toggle.
- Full: g_wptr_sync=gray(8)=4'b1100 with b_rptr=0 -> empty=0, r_count=8, almost_empty=0. Then read once -> r_count=7.
- Pointer error: force g_wptr_sync=gray(12)=4'b1010 with b_rptr=0 -> ptr_err=1 and r_count saturated at 8.
